// File: rtl/xpb_table_gen_pkg.sv
// Shared constants and state encoding for the xpb table generator.
package xpb_table_gen_pkg;

  localparam int NUM_ENTRIES = 32;
  localparam int IDX_W       = 5;
  localparam int WORD_W      = 1024;

  // Index of the final table entry; its handshake ends the table.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    ADD    = 2'd2,
    REDUCE = 2'd3
  } state_e;

endpackage

// File: rtl/xpb_table_gen_acc_step.sv
// One accumulation step: registers acc + base (1025 bits) when load_i is
// high, then combinationally applies the conditional modular subtraction.
module xpb_acc_step
  import xpb_table_gen_pkg::*;
(
  input  logic              clk,
  input  logic              load_i,
  input  logic [WORD_W-1:0] acc_i,
  input  logic [WORD_W-1:0] base_i,
  input  logic [WORD_W-1:0] modulus_i,
  input  logic              reduce_en_i,
  output logic [WORD_W-1:0] acc_next_o
);

  logic [WORD_W:0] sum_q;
  logic [WORD_W:0] sum_d;

  // Next sum: capture the full-width addition only in the ADD cycle.
  always_comb begin
    sum_d = sum_q;
    if (load_i) begin
      sum_d = {1'b0, acc_i} + {1'b0, base_i};
    end
  end

  // Sum register at the ADD/REDUCE boundary.
  // NOTE: pure datapath register with no reset; the FSM only reads it in
  // REDUCE, which always follows a load, so its power-up value never matters.
  always_ff @(posedge clk) begin
    sum_q <= sum_d;
  end

  // Compare-subtract: both operands are below the modulus when reducing, so
  // sum < 2*modulus and the 1024-bit difference is exact.
  always_comb begin
    acc_next_o = sum_q[WORD_W-1:0];
    if (reduce_en_i && (sum_q >= {1'b0, modulus_i})) begin
      acc_next_o = sum_q[WORD_W-1:0] - modulus_i;
    end
  end

endmodule

// File: rtl/xpb_table_gen.sv
// Generates the 32-entry xpb table k*base (optionally mod modulus) and
// streams it out over a valid/ready interface, one entry every 3 cycles.
module xpb_table_gen
  import xpb_table_gen_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] base,
  input  logic [WORD_W-1:0] modulus,
  input  logic              reduce_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_addr,
  output logic [WORD_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              done_q, done_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] base_q, base_d;
  logic [WORD_W-1:0] modulus_q, modulus_d;
  logic              reduce_en_q, reduce_en_d;
  logic              step_load;
  logic [WORD_W-1:0] step_acc;

  xpb_acc_step u_acc_step (
    .clk         (clk),
    .load_i      (step_load),
    .acc_i       (acc_q),
    .base_i      (base_q),
    .modulus_i   (modulus_q),
    .reduce_en_i (reduce_en_q),
    .acc_next_o  (step_acc)
  );

  // Next-state and datapath control; the only handshake is EMIT & out_ready.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    base_d      = base_q;
    modulus_d   = modulus_q;
    reduce_en_d = reduce_en_q;
    done_d      = 1'b0;
    step_load   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = base;
          modulus_d   = modulus;
          reduce_en_d = reduce_en;
          acc_d       = '0;
          idx_d       = '0;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ADD;
          end
        end
      end
      ADD: begin
        step_load = 1'b1;
        state_d   = REDUCE;
      end
      REDUCE: begin
        acc_d   = step_acc;
        idx_d   = idx_q + IDX_W'(1);
        state_d = EMIT;
      end
      default: state_d = IDLE;
    endcase

    // Registered valid: depends on next state, never on out_ready directly
    // at the output pin.
    out_valid_d = (state_d == EMIT);
  end

  // Control and accumulator state, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Latched table parameters; only written when a start is accepted.
  always_ff @(posedge clk) begin
    base_q      <= base_d;
    modulus_q   <= modulus_d;
    reduce_en_q <= reduce_en_d;
  end

  assign out_valid = out_valid_q;
  assign out_addr  = idx_q;
  assign out_data  = acc_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Self-checking bench for xpb_table_gen: directed and randomized tables
// checked against an arithmetic model (k*base mod m, or mod 2^1024).
module tb_xpb_table_gen;
  import xpb_table_gen_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [WORD_W-1:0] base;
  logic [WORD_W-1:0] modulus;
  logic              reduce_en;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_addr;
  logic [WORD_W-1:0] out_data;
  logic              busy;
  logic              done;

  xpb_table_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .modulus   (modulus),
    .reduce_en (reduce_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Parameters of the table currently expected from the DUT.
  logic [WORD_W-1:0] exp_base, exp_mod;
  logic              exp_red;
  // Data accepted for each address in the most recent table.
  logic [WORD_W-1:0] seen_data [NUM_ENTRIES];

  task automatic check(input string tag, input logic [WORD_W-1:0] obs,
                       input logic [WORD_W-1:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed hi=%h lo=%h expected hi=%h lo=%h", tag,
             obs[WORD_W-1 -: 64], obs[63:0], exp_v[WORD_W-1 -: 64], exp_v[63:0]);
    end
  endtask

  // Reference: entry k is k*base, reduced mod modulus or truncated to 1024 bits.
  function automatic logic [WORD_W-1:0] golden(input int k, input logic [WORD_W-1:0] b,
                                               input logic [WORD_W-1:0] m, input logic r);
    logic [WORD_W+5:0] kk, prod, rem;
    kk       = '0;
    kk[5:0]  = k[5:0];
    prod     = kk * {6'd0, b};
    rem      = r ? (prod % {6'd0, m}) : prod;
    return rem[WORD_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] rand_word();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic start_table(input logic [WORD_W-1:0] b, input logic [WORD_W-1:0] m,
                             input logic r);
    base = b; modulus = m; reduce_en = r; start = 1'b1;
    exp_base = b; exp_mod = m; exp_red = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Consumes one table, entered on the sample right after the accepting edge.
  // reset_at: entry whose handshake cycle gets a reset (-1: none).
  // poke_at:  entry during whose first presentation start is pulsed with junk.
  // chain:    hold start high across done with parameters nb/nm/nr.
  // done_cyc: sample index (edges since start) at which done was seen.
  task automatic consume(input int ready_pct, input int reset_at, input int poke_at,
                         input logic chain, input logic [WORD_W-1:0] nb,
                         input logic [WORD_W-1:0] nm, input logic nr, output int done_cyc);
    int k = 0, cyc = 1, hs_cyc = -2;
    logic pv = 1'b0, pr = 1'b0, fresh = 1'b1, hs, rst_now;
    logic [IDX_W-1:0]  pa = '0;
    logic [WORD_W-1:0] pd = '0;
    done_cyc = -1;
    forever begin
      if (cyc > 4000) begin
        n_checks++; n_fail++;
        $error("FAIL timeout: table not finished after %0d cycles, entry %0d", cyc, k);
        break;
      end
      check("done low mid-table", done, 1'b0);
      check("busy mid-table", busy, 1'b1);
      if (out_valid) begin
        fresh = !(pv && !pr);
        if (fresh) check($sformatf("latency k=%0d", k), cyc, hs_cyc + 3);
        else begin
          check($sformatf("stall addr k=%0d", k), out_addr, pa);
          check($sformatf("stall data k=%0d", k), out_data, pd);
        end
        check($sformatf("addr k=%0d", k), out_addr, k);
        check($sformatf("data k=%0d", k), out_data, golden(k, exp_base, exp_mod, exp_red));
      end else if (pv && !pr) begin
        check($sformatf("valid dropped k=%0d", k), out_valid, 1'b1);
      end
      out_ready = ($urandom_range(99) < ready_pct);
      start     = 1'b0;
      rst_now   = 1'b0;
      if (out_valid && k == reset_at) begin
        out_ready = 1'b1; reset = 1'b1; rst_now = 1'b1;
      end
      if (out_valid && fresh && k == poke_at) begin
        start = 1'b1; base = rand_word(); modulus = rand_word() | 1; reduce_en = ~exp_red;
      end
      hs = out_valid && out_ready;
      if (hs && k == NUM_ENTRIES - 1 && chain) begin
        start = 1'b1; base = nb; modulus = nm; reduce_en = nr;
      end
      if (hs) seen_data[k] = out_data;
      pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data;
      @(posedge clk); #1; cyc++;
      if (rst_now) begin
        reset = 1'b0;
        check("reset valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset addr", out_addr, '0);
        check("reset data", out_data, '0);
        for (int j = 0; j < 40; j++) begin
          @(posedge clk); #1;
          check("post-abort valid", out_valid, 1'b0);
          check("post-abort done", done, 1'b0);
        end
        break;
      end
      if (hs) begin
        hs_cyc = cyc - 1;
        if (k == NUM_ENTRIES - 1) begin
          done_cyc = cyc;
          check("done pulse", done, 1'b1);
          check("idle after table busy", busy, 1'b0);
          check("idle after table valid", out_valid, 1'b0);
          @(posedge clk); #1;
          check("done single cycle", done, 1'b0);
          if (chain) begin
            start = 1'b0;
            check("chained entry0 valid", out_valid, 1'b1);
            check("chained entry0 addr", out_addr, '0);
            check("chained entry0 data", out_data, '0);
            exp_base = nb; exp_mod = nm; exp_red = nr;
          end else begin
            check("idle valid", out_valid, 1'b0);
          end
          break;
        end
        k++;
      end
    end
  endtask

  initial begin
    int dc;
    logic [WORD_W-1:0] b, m, top;
    top = '0; top[WORD_W-1] = 1'b1;

    // Reset has priority over a held start and out_ready.
    reset = 1'b1; start = 1'b1; out_ready = 1'b1;
    base = 3; modulus = 64; reduce_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst addr", out_addr, '0);
    check("rst data", out_data, '0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("idle no start", busy, 1'b0);

    // Small modulus, full-rate consumer: 95 cycles start-to-done.
    start_table(3, 64, 1'b1);
    consume(100, -1, -1, 1'b0, '0, '0, 1'b0, dc);
    check("table time", dc, 95);
    check("entry 21", seen_data[21], 63);
    check("entry 22", seen_data[22], 2);
    check("entry 31", seen_data[31], 29);

    // Truncation: base = 2^1023 without reduction alternates 0 / 2^1023.
    start_table(top, rand_word() | 1, 1'b0);
    consume(100, -1, -1, 1'b0, '0, '0, 1'b0, dc);
    for (int k = 0; k < NUM_ENTRIES; k++)
      check($sformatf("trunc k=%0d", k), seen_data[k], (k % 2 == 1) ? top : '0);

    // Sum landing exactly on the modulus, throttled.
    start_table(4, 64, 1'b1);
    consume(60, -1, -1, 1'b0, '0, '0, 1'b0, dc);
    check("exact-mod entry 16", seen_data[16], 0);

    // Random wide operands with throttled consumer, reduction on and off.
    for (int t = 0; t < 3; t++) begin
      m = rand_word() | 1;
      b = rand_word() % m;
      start_table(b, m, 1'b1);
      consume(60, -1, -1, 1'b0, '0, '0, 1'b0, dc);
    end
    start_table(rand_word(), rand_word() | 1, 1'b0);
    consume(60, -1, -1, 1'b0, '0, '0, 1'b0, dc);

    // start pulsed with new operands mid-table is ignored.
    m = rand_word() | 1; b = rand_word() % m;
    start_table(b, m, 1'b1);
    consume(100, -1, 10, 1'b0, '0, '0, 1'b0, dc);
    check("poke table time", dc, 95);

    // Reset at the handshake of entry 17 aborts; a fresh table is complete.
    start_table(5, 97, 1'b1);
    consume(100, 17, -1, 1'b0, '0, '0, 1'b0, dc);
    m = rand_word() | 1; b = rand_word() % m;
    start_table(b, m, 1'b1);
    consume(70, -1, -1, 1'b0, '0, '0, 1'b0, dc);

    // start held high at done launches the next table back to back.
    m = rand_word() | 1; b = rand_word() % m;
    start_table(7, 101, 1'b1);
    consume(100, -1, -1, 1'b1, b, m, 1'b1, dc);
    consume(100, -1, -1, 1'b0, '0, '0, 1'b0, dc);
    check("chained table time", dc, 95);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xpb_table_gen.md
XPB_TABLE_GEN -- requirements
Module: xpb_table_gen

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on posedge clk.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle request to generate a table; sampled only in IDLE.
REQ-004 SHALL have port: base  input  [1024:1]  table step constant; latched on accepted start; must be < modulus when reduction is enabled.
REQ-005 SHALL have port: modulus  input  [1024:1]  reduction modulus; latched on accepted start.
REQ-006 SHALL have port: reduce_en  input  1  latched on accepted start; 1 = entries mod modulus, 0 = plain multiples truncated to 1024 bits.
REQ-007 SHALL have port: out_valid  output  1  entry present on out_addr/out_data.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts the entry when out_valid & out_ready.
REQ-009 SHALL have port: out_addr  output  [5:1]  table index k of the presented entry.
REQ-010 SHALL have port: out_data  output  [1024:1]  entry k, the 1024-bit xpb word for selector value k.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse after entry 31 is accepted.

Function
REQ-013 SHALL implement the states IDLE, EMIT, ADD and REDUCE.
REQ-014 In IDLE with start=1, SHALL latch base, modulus and reduce_en, clear acc and idx to 0, and enter EMIT on the next cycle.
REQ-015 In EMIT, SHALL drive out_valid=1, out_addr=idx and out_data=acc, holding all three stable until the handshake.
REQ-016 On an EMIT handshake with idx=31, SHALL return to IDLE and assert done for exactly that next cycle.
REQ-017 On an EMIT handshake with idx<31, SHALL enter ADD.
REQ-018 In ADD, SHALL register a 1025-bit sum = acc + base_latched and then enter REDUCE.
REQ-019 In REDUCE, if reduce_en_latched=1 and sum >= modulus_latched, SHALL set acc = sum - modulus_latched; otherwise SHALL set acc = sum[1024:1].
REQ-020 In REDUCE, SHALL increment idx and enter EMIT.
REQ-021 Latency: entry 0 SHALL be valid 1 cycle after the accepted start.
REQ-022 Latency: entry k+1 SHALL be valid 3 cycles after the handshake of entry k, i.e. the cycle after handshake is ADD, then REDUCE, then EMIT.
REQ-023 Minimum table time with out_ready held high SHALL be 1 + 32 + 31*2 = 95 cycles from start to done.
REQ-024 Entry k SHALL equal (k*base) mod modulus when reduction is on, and (k*base) mod 2^1024 when it is off, for every k in 0..31.
REQ-025 start SHALL be ignored while busy; a held start SHALL NOT corrupt an in-flight table.
REQ-026 out_valid SHALL NOT drop without a handshake, regardless of out_ready.
REQ-027 out_data SHALL be unchanged and out_addr constant while stalled (out_ready low).
REQ-028 out_valid SHALL be 0 in IDLE, ADD and REDUCE.
REQ-029 Changes on base, modulus or reduce_en after start is accepted SHALL have no effect until the next table.
REQ-030 A start arriving in the same cycle as done SHALL be accepted, since the FSM is in IDLE that cycle.

Reset
REQ-031 While reset=1, SHALL force state=IDLE, idx=0, acc=0, out_valid=0, busy=0, done=0 and out_addr=0.
REQ-032 reset SHALL take priority over start and out_ready.
REQ-033 A reset asserted mid-table SHALL abort the table; no further entries or done pulse SHALL be produced.

Structure
REQ-034 A shared package SHALL hold NUM_ENTRIES=32, IDX_W=5, WORD_W=1024 and the state enumeration.
REQ-035 The 1025-bit add and compare-subtract SHALL be one sub-module, xpb_acc_step, registered at the ADD/REDUCE boundary only.
REQ-036 The output stage SHALL be registered, with no combinational path from out_ready to out_valid.

Verification
REQ-037 base=3, modulus=64, reduce_en=1, out_ready=1 -> entries 0,3,...,63,2,5,...,29 (k=21 gives 63, k=22 gives 2); done pulses at cycle 95.
REQ-038 base=1<<1023, reduce_en=0 -> entry 0 = 0, odd k = 1<<1023, even k = 0 (truncation check).
REQ-039 Random out_ready throttling (~40% low) -> every (addr, data) pair matches the golden model exactly once; no drop or change while stalled.
REQ-040 start pulsed at entry 10 with new base -> table continues with the original base; done fires once.
REQ-041 reset asserted at the handshake of entry 17 -> out_valid=0 next cycle and no done; fresh start yields a full correct table.
REQ-042 start held high at done -> a second table begins immediately; entry 0 is valid on the cycle after done.
